// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider: restoring radix-2 mantissa divide, one quotient bit per cycle.
// Define FP_DIV_ROUND_MODES_EN to add the rm port (RISC-V rounding modes); otherwise RNE only.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FP_DIV_ROUND_MODES_EN
  input  logic [2:0]           rm,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 invalid,
  output logic                 div_by_zero,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int RW = MAN_W + 2;
  localparam int CW = $clog2(N);
  localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [MAN_W:0]  dvs_q, dvs_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            nv_q, nv_d, dz_q, dz_d, of_q, of_d, uf_q, uf_d;
`ifdef FP_DIV_ROUND_MODES_EN
  logic [2:0]      rm_q, rm_d;
  logic            inexact;
`endif

  logic             sa, sb, s_res;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             spec_nan, is_special;
  logic [RW:0]      trial;
  logic             neg;

  logic             norm, g, r, s, round_up, sat_max, carry, ovf, unf;
  logic [MAN_W-1:0] frac_t, frac_r;
  logic [EW-1:0]    exp_n, exp_r;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign s_res = sa ^ sb;

  // Zero exponent flushes the operand to zero, so subnormals never reach the datapath.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign spec_nan   = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  assign trial = {1'b0, rem_q} - {2'b00, dvs_q};
  assign neg   = trial[RW];

  // Quotient MSB has weight 1; when clear the ratio was below one and needs a 1-bit left shift.
  assign norm   = quo_q[N-1];
  assign frac_t = norm ? quo_q[N-2:3] : quo_q[N-3:2];
  assign g      = norm ? quo_q[2] : quo_q[1];
  assign r      = norm ? quo_q[1] : quo_q[0];
  assign s      = (norm & quo_q[0]) | (|rem_q);
  assign exp_n  = norm ? exp_q : exp_q - EW'(1);
`ifdef FP_DIV_ROUND_MODES_EN
  assign inexact = g | r | s;
`endif

  always_comb begin
    round_up = g & (r | s | frac_t[0]);
    sat_max  = 1'b0;
`ifdef FP_DIV_ROUND_MODES_EN
    case (rm_q)
      3'b001: begin round_up = 1'b0;             sat_max = 1'b1;    end
      3'b010: begin round_up = sign_q & inexact;  sat_max = ~sign_q; end
      3'b011: begin round_up = ~sign_q & inexact; sat_max = sign_q;  end
      3'b100: round_up = g;
      default: ;
    endcase
`endif
  end

  assign {carry, frac_r} = {1'b0, frac_t} + (MAN_W+1)'(round_up);
  assign exp_r = exp_n + EW'(carry);
  assign ovf   = ~exp_r[EW-1] && (exp_r >= EMAX);
  assign unf   = exp_r[EW-1] || (exp_r == '0);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    nv_d     = nv_q;
    dz_d     = dz_q;
    of_d     = of_q;
    uf_d     = uf_q;
`ifdef FP_DIV_ROUND_MODES_EN
    rm_d     = rm_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = s_res;
          nv_d   = 1'b0;
          dz_d   = 1'b0;
          of_d   = 1'b0;
          uf_d   = 1'b0;
`ifdef FP_DIV_ROUND_MODES_EN
          rm_d   = rm;
`endif
          exp_d  = {2'b00, ea} - {2'b00, eb} + BIAS;
          rem_d  = {1'b0, 1'b1, fa};
          dvs_d  = {1'b1, fb};
          quo_d  = '0;
          cnt_d  = '0;
          state_d = is_special ? DONE : DIV;
          if (spec_nan) begin
            result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            nv_d     = 1'b1;
          end else if (b_zero && !a_inf) begin
            result_d = {s_res, EXP_ONES, {MAN_W{1'b0}}};
            dz_d     = 1'b1;
          end else if (a_inf) begin
            result_d = {s_res, EXP_ONES, {MAN_W{1'b0}}};
          end else if (a_zero || b_inf) begin
            result_d = {s_res, {(W-1){1'b0}}};
          end
        end
      end
      DIV: begin
        quo_d = {quo_q[N-2:0], ~neg};
        rem_d = neg ? (rem_q << 1) : (trial[RW-1:0] << 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = RND;
      end
      RND: begin
        if (ovf) begin
          of_d     = 1'b1;
          result_d = sat_max ? {sign_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}}
                             : {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (unf) begin
          uf_d     = 1'b1;
          result_d = {sign_q, {(W-1){1'b0}}};
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      nv_q     <= 1'b0;
      dz_q     <= 1'b0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
`ifdef FP_DIV_ROUND_MODES_EN
      rm_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      nv_q     <= nv_d;
      dz_q     <= dz_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
`ifdef FP_DIV_ROUND_MODES_EN
      rm_q     <= rm_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign invalid     = nv_q;
  assign div_by_zero = dz_q;
  assign overflow    = of_q;
  assign underflow   = uf_q;

endmodule
